// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point multiplier.
//   fp_class_e   - operand classification produced by fp_unpack
//   fp_special_e - special-result selector carried down the pipeline
//   FLG_*        - bit positions inside the 4-bit flags word
//   fp_bias()    - exponent bias for a given exponent width
//   fp_qnan()    - canonical quiet NaN pattern (LSB-aligned, zero-extended to 64 bits)
package fp_pkg;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_QNAN,
        SP_INF,
        SP_ZERO
    } fp_special_e;

    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_NX  = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // {0, all-ones exponent, 1, 0...}; callers slice the low W bits.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] q;
        q = ((64'd1 << exp_w) - 64'd1) << man_w;
        q = q | (64'd1 << (man_w - 1));
        return q;
    endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
// Handshake: a beat transfers on a channel in the cycle where its valid and
// ready are both high; a producer holding valid keeps its payload stable.
//   in_valid/in_ready/a/b            - operand channel (master -> slave)
//   out_valid/out_ready/result/flags - result channel (slave -> master)
// Modports: master = operand producer / result consumer, slave = multiplier.
interface fp_mul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = EXP_W + MAN_W + 1;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/fp_unpack.sv
// Combinational operand classifier.
//   op    - packed operand {sign, exp, frac}
//   sign  - sign bit
//   exp_f - biased exponent field
//   cls   - zero (exp=0, denormals flushed), inf, nan or normal
//   sig   - significand with hidden bit inserted (0 for non-normal classes)
//   snan  - operand is a signalling NaN (frac MSB clear)
module fp_unpack
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = EXP_W + MAN_W + 1
) (
    input  logic [W-1:0]     op,
    output logic             sign,
    output logic [EXP_W-1:0] exp_f,
    output fp_class_e        cls,
    output logic [MAN_W:0]   sig,
    output logic             snan
);

    logic [MAN_W-1:0] frac;

    assign sign  = op[W-1];
    assign exp_f = op[W-2:MAN_W];
    assign frac  = op[MAN_W-1:0];

    always_comb begin
        cls  = FP_NORM;
        sig  = {1'b1, frac};
        snan = 1'b0;
        if (exp_f == '0) begin
            cls = FP_ZERO;
            sig = '0;
        end else if (exp_f == '1) begin
            sig = '0;
            if (frac == '0) begin
                cls = FP_INF;
            end else begin
                cls  = FP_NAN;
                snan = ~frac[MAN_W-1];
            end
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage pipelined floating-point multiplier (unpack / multiply / round+pack).
//   clk - rising-edge clock
//   rst - synchronous active-high reset; discards everything in flight
//   bus - fp_mul_pipe_if.slave: operands a/b in, result/flags out
// The whole pipeline advances together when the output register is empty
// or being drained, so in_ready is that same advance condition.
// Build option FP_MUL_RNE_EN: defined selects round-to-nearest-even with
// overflow to Inf; undefined truncates and overflows to the max finite value.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic            clk,
    input  logic            rst,
    fp_mul_pipe_if.slave    bus
);

    localparam int W  = EXP_W + MAN_W + 1;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;

    localparam logic signed [EW-1:0] BIAS_E = EW'(fp_bias(EXP_W));
    localparam logic signed [EW-1:0] EMAX   = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic [63:0]          QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]         QNAN = QNAN_WIDE[W-1:0];

    logic advance;
    logic accept;

    assign advance     = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;
    assign accept      = bus.in_valid && advance;

    // ---------------- stage 1: unpack ----------------
    logic             sign_a, sign_b, snan_a, snan_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    fp_class_e        cls_a, cls_b;
    logic [MAN_W:0]   sig_a, sig_b;

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .op(bus.a), .sign(sign_a), .exp_f(exp_a), .cls(cls_a), .sig(sig_a), .snan(snan_a)
    );
    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .op(bus.b), .sign(sign_b), .exp_f(exp_b), .cls(cls_b), .sig(sig_b), .snan(snan_b)
    );

    logic signed [EW-1:0] e_sum;
    fp_special_e          sp_d;
    logic                 inv_d;

    assign e_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_E;

    // NaN beats Inf x 0, which beats Inf, which beats zero.
    always_comb begin
        sp_d  = SP_NONE;
        inv_d = 1'b0;
        if (cls_a == FP_NAN || cls_b == FP_NAN) begin
            sp_d  = SP_QNAN;
            inv_d = snan_a | snan_b;
        end else if ((cls_a == FP_INF && cls_b == FP_ZERO) ||
                     (cls_a == FP_ZERO && cls_b == FP_INF)) begin
            sp_d  = SP_QNAN;
            inv_d = 1'b1;
        end else if (cls_a == FP_INF || cls_b == FP_INF) begin
            sp_d = SP_INF;
        end else if (cls_a == FP_ZERO || cls_b == FP_ZERO) begin
            sp_d = SP_ZERO;
        end
    end

    logic                 s1_valid, s1_sign, s1_inv;
    logic signed [EW-1:0] s1_exp;
    logic [MAN_W:0]       s1_ma, s1_mb;
    fp_special_e          s1_sp;

    // ---------------- stage 2: multiply ----------------
    logic                 s2_valid, s2_sign, s2_inv;
    logic signed [EW-1:0] s2_exp;
    logic [PW-1:0]        s2_prod;
    fp_special_e          s2_sp;

    // ---------------- stage 3: normalise / round / pack ----------------
    logic [PW-1:0]        norm;
    logic [MAN_W:0]       mant;
    logic                 guard, sticky;
    logic signed [EW-1:0] e_n, e_r;
    logic [MAN_W-1:0]     frac;
    logic [W-1:0]         ovf_val;
    logic [W-1:0]         s3_result;
    logic [3:0]           s3_flags;

    // Product lies in [1,4); an MSB of 1 means the [2,4) case.
    assign norm   = s2_prod[PW-1] ? s2_prod : (s2_prod << 1);
    assign mant   = norm[PW-1:MAN_W+1];
    assign guard  = norm[MAN_W];
    assign sticky = |norm[MAN_W-1:0];
    assign e_n    = s2_exp + $signed({{(EW-1){1'b0}}, s2_prod[PW-1]});

`ifdef FP_MUL_RNE_EN
    logic             round_up;
    logic [MAN_W+1:0] mant_r;
    logic             rnd_carry;
    logic             unused_hidden;

    assign round_up  = guard & (sticky | mant[0]);
    assign mant_r    = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};
    // Carry out means mantissa rolled to 2.0: renormalise to 1.0, bump exponent.
    assign rnd_carry = mant_r[MAN_W+1];
    assign frac      = rnd_carry ? '0 : mant_r[MAN_W-1:0];
    assign e_r       = e_n + $signed({{(EW-1){1'b0}}, rnd_carry});
    assign ovf_val   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign unused_hidden = mant_r[MAN_W];
`else
    logic unused_hidden;

    assign frac    = mant[MAN_W-1:0];
    assign e_r     = e_n;
    assign ovf_val = {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    assign unused_hidden = mant[MAN_W];
`endif

    always_comb begin
        s3_result         = {s2_sign, e_r[EXP_W-1:0], frac};
        s3_flags          = '0;
        s3_flags[FLG_NX]  = guard | sticky;
        if (e_r >= EMAX) begin
            s3_result        = ovf_val;
            s3_flags[FLG_OVF] = 1'b1;
            s3_flags[FLG_NX]  = 1'b1;
        end else if (e_r <= E_ZERO) begin
            s3_result        = {s2_sign, {(W-1){1'b0}}};
            s3_flags[FLG_UNF] = 1'b1;
            s3_flags[FLG_NX]  = 1'b1;
        end
        case (s2_sp)
            SP_QNAN: begin
                s3_result         = QNAN;
                s3_flags          = '0;
                s3_flags[FLG_INV] = s2_inv;
            end
            SP_INF: begin
                s3_result = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                s3_flags  = '0;
            end
            SP_ZERO: begin
                s3_result = {s2_sign, {(W-1){1'b0}}};
                s3_flags  = '0;
            end
            default: ;
        endcase
    end

    // ---------------- pipeline registers ----------------
    logic         out_valid_q;
    logic [W-1:0] result_q;
    logic [3:0]   flags_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_inv      <= 1'b0;
            s1_exp      <= '0;
            s1_ma       <= '0;
            s1_mb       <= '0;
            s1_sp       <= SP_NONE;
            s2_valid    <= 1'b0;
            s2_sign     <= 1'b0;
            s2_inv      <= 1'b0;
            s2_exp      <= '0;
            s2_prod     <= '0;
            s2_sp       <= SP_NONE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (advance) begin
            s1_valid    <= accept;
            s1_sign     <= sign_a ^ sign_b;
            s1_inv      <= inv_d;
            s1_exp      <= e_sum;
            s1_ma       <= sig_a;
            s1_mb       <= sig_b;
            s1_sp       <= sp_d;
            s2_valid    <= s1_valid;
            s2_sign     <= s1_sign;
            s2_inv      <= s1_inv;
            s2_exp      <= s1_exp;
            s2_prod     <= PW'(s1_ma) * PW'(s1_mb);
            s2_sp       <= s1_sp;
            out_valid_q <= s2_valid;
            result_q    <= s3_result;
            flags_q     <= s3_flags;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed-vector bench for fp_mul_pipe with a queue-based scoreboard.
// Expected results for both rounding builds are hand-computed below.
module tb_fp_mul_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = EXP_W + MAN_W + 1;
    localparam int NV    = 14;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fp_mul_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W+3:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] va[NV];
    logic [W-1:0] vb[NV];
    logic [W-1:0] vr[NV];
    logic [3:0]   vf[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic set_vec(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] r, input logic [3:0] f);
        va[i] = a;
        vb[i] = b;
        vr[i] = r;
        vf[i] = f;
    endtask

    task automatic init_vectors();
        set_vec(0,  32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000); // 1.5 * 2
        set_vec(1,  32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000); // -2 * 3
        set_vec(2,  32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001); // sticky only
        set_vec(3,  32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000); // Inf * 0
`ifdef FP_MUL_RNE_EN
        set_vec(4,  32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101); // overflow -> Inf
`else
        set_vec(4,  32'h7F000000, 32'h7F000000, 32'h7F7FFFFF, 4'b0101); // overflow -> max finite
`endif
        set_vec(5,  32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011); // underflow flush
        set_vec(6,  32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000); // sNaN
        set_vec(7,  32'h7FC00000, 32'h40000000, 32'h7FC00000, 4'b0000); // qNaN
        set_vec(8,  32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000); // Inf * -2
        set_vec(9,  32'h80000000, 32'h40400000, 32'h80000000, 4'b0000); // -0 * 3
        set_vec(10, 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000); // denormal flushed
`ifdef FP_MUL_RNE_EN
        set_vec(11, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001); // tie, odd -> up
`else
        set_vec(11, 32'h3F800001, 32'h3FC00000, 32'h3FC00001, 4'b0001);
`endif
        set_vec(12, 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001); // tie, even -> stay
`ifdef FP_MUL_RNE_EN
        set_vec(13, 32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'b0001); // rounding carry
`else
        set_vec(13, 32'h3FFFFFFE, 32'h3F800001, 32'h3FFFFFFF, 4'b0001);
`endif
    endtask

    // Offer one operand pair; push the expectation once the DUT takes it.
    task automatic issue(input int i);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = va[i];
        bus.b = vb[i];
        #1;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: vector %0d not accepted, in_ready %b want 1", i, bus.in_ready);
            bus.in_valid = 1'b0;
        end else begin
            exp_q.push_back({vr[i], vf[i]});
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    // Issue one op into an empty pipe and count cycles until out_valid.
    task automatic latency_test(input int i, input string name);
        int n;
        issue(i);
        n = 0;
        do begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            n++;
            #2;
        end while (!bus.out_valid && n < 10);
        check(name, 64'(n), 64'd3);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        idle(1);
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        idle(2);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor: compare every transferred result against the queue,
    // and require result/flags to hold while the consumer stalls.
    logic         prev_stall = 1'b0;
    logic [W+3:0] prev_out;

    always @(negedge clk) begin
        logic [W+3:0] e;
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("hold_while_stalled", 64'({bus.result, bus.flags}), 64'(prev_out));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got result %h flags %b, want no output",
                             bus.result, bus.flags);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'(bus.result), 64'(e[W+3:4]));
                    check("flags", 64'(bus.flags), 64'(e[3:0]));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.result, bus.flags};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t want < 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        init_vectors();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_result", 64'(bus.result), 64'd0);
        check("reset_flags", 64'(bus.flags), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);

        // First op into an empty pipe: exactly three cycles to out_valid.
        latency_test(0, "latency_first");
        drain("drain_first");

        // Directed vectors, back to back.
        for (int i = 1; i < NV; i++) issue(i);
        drain("drain_directed");

        // Four-op stream with the consumer stalled for five cycles mid-stream.
        fork
            begin
                issue(1);
                issue(2);
                issue(11);
                issue(13);
                idle(1);
            end
            begin
                repeat (4) @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (4) @(negedge clk);
                #1;
                check("stall_out_valid", 64'(bus.out_valid), 64'd1);
                check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain("drain_stream");

        // Reset with two ops in flight: neither may ever appear.
        issue(4);
        issue(5);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("post_reset_in_ready", 64'(bus.in_ready), 64'd1);
        idle(6);
        latency_test(1, "latency_after_reset");
        drain("drain_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
